mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL take parameter AW, default 16: address width.
REQ-002 SHALL take parameter DW, default 32: data width.
REQ-003 SHALL take parameter MEM_LAT, default 2: memory access cycles; legal range 1..15.
REQ-004 SHALL have port clk  in  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port rst_f  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req in 1 (fetch request), if_addr in AW.
REQ-007 SHALL have ports if_gnt out 1, if_done out 1, if_rdata out DW.
REQ-008 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in AW, dm_wdata in DW.
REQ-009 SHALL have ports dm_gnt out 1, dm_done out 1, dm_rdata out DW.
REQ-010 SHALL have memory-side ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW.
REQ-011 SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-012 SHALL implement three states: IDLE, ACCESS, DONE.
REQ-013 IDLE, no request: SHALL stay in IDLE; all grants, dones and mem_en low.
REQ-014 IDLE, one request: SHALL grant that requester at the next edge and enter ACCESS.
REQ-015 IDLE, both requests: SHALL grant the requester not served last (round-robin); the last-served bit resets to "data", so fetch wins the first tie.
REQ-016 On grant SHALL latch the winner's address, write enable (forced 0 for fetch) and write data into mem_addr/mem_we/mem_wdata, and load a latency counter with MEM_LAT-1.
REQ-017 ACCESS: mem_en and the winner's gnt SHALL be high.
- mem_addr, mem_we and mem_wdata SHALL stay stable.
- Counter SHALL decrement each cycle.
REQ-018 ACCESS with counter 0:
- Reads: SHALL capture mem_rdata into the winner's rdata register.
- SHALL enter DONE.
- ACCESS therefore lasts exactly MEM_LAT cycles.
REQ-019 DONE: SHALL pulse the winner's done high for exactly one cycle; gnt and mem_en low; SHALL update the last-served bit; next state IDLE.
REQ-020 Latency: request seen in IDLE at cycle 0 -> gnt cycles 1..MEM_LAT -> done cycle MEM_LAT+1 -> IDLE cycle MEM_LAT+2.
- Sustained throughput: one access per MEM_LAT+2 cycles.
REQ-021 Request sampling SHALL occur only in IDLE.
- Requests arriving in ACCESS/DONE SHALL wait for the next IDLE.
- A request dropped mid-access SHALL NOT abort it; done still pulses.
REQ-022 Writes: rdata registers SHALL hold their previous value.
REQ-023 if_rdata and dm_rdata SHALL hold their value until overwritten by a later read of the same requester.
REQ-024 At most one of if_gnt/dm_gnt and one of if_done/dm_done SHALL be high in any cycle.
REQ-025 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs low.

Reset
REQ-026 While rst_f is low, regardless of clk:
- state SHALL be IDLE, counter 0, last-served = data.
- All gnt, done, mem_en, mem_we and busy SHALL be 0.
- mem_addr, mem_wdata, if_rdata and dm_rdata SHALL be 0.
REQ-027 Reset asserted mid-ACCESS SHALL abandon the access with no done pulse; the first arbitration after release SHALL behave as from power-up.

Verification
REQ-028 MEM_LAT=2, if_req=1, if_addr=0x0010, mem_rdata=0xDEADBEEF -> if_gnt cycles 1-2, mem_en=1, mem_we=0, if_done=1 at cycle 3, if_rdata=0xDEADBEEF.
REQ-029 Both requests held high from reset release, dm_we=1, dm_addr=0x0020, dm_wdata=0x12345678 -> fetch served first; data served second with mem_we=1, mem_addr=0x0020, mem_wdata=0x12345678; then fetch again (alternation).
REQ-030 dm_req raised in cycle 2 of a fetch ACCESS -> not granted until the IDLE after if_done; dm_gnt never overlaps if_gnt.
REQ-031 rst_f pulsed low during ACCESS -> outputs immediately 0, no done pulse; a new if_req after release completes normally in MEM_LAT+1 cycles.
REQ-032 MEM_LAT=1 and MEM_LAT=15, single dm read -> dm_done exactly 2 and 16 cycles after request; busy high throughout ACCESS/DONE.
REQ-033 Data write after a data read of 0xA5A5A5A5 -> dm_rdata still 0xA5A5A5A5 after write done.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory.
// Round-robin on ties; each access is IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
module mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_dm;
  logic       win_dm;
  logic       pick_dm;

  // On a tie the data port wins only if fetch was served last.
  assign pick_dm = dm_req && (!if_req || !last_dm);
  assign busy    = (state == ACCESS) || (state == DONE);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dm   <= 1'b1;
      win_dm    <= 1'b0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          if (if_req || dm_req) begin
            state     <= ACCESS;
            win_dm    <= pick_dm;
            if_gnt    <= !pick_dm;
            dm_gnt    <= pick_dm;
            mem_en    <= 1'b1;
            mem_addr  <= pick_dm ? dm_addr : if_addr;
            mem_we    <= pick_dm && dm_we;
            mem_wdata <= pick_dm ? dm_wdata : '0;
            cnt       <= LAT_M1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            if_gnt  <= 1'b0;
            dm_gnt  <= 1'b0;
            mem_en  <= 1'b0;
            if_done <= !win_dm;
            dm_done <= win_dm;
            if (!mem_we) begin
              if (win_dm) dm_rdata <= mem_rdata;
              else        if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          if_done <= 1'b0;
          dm_done <= 1'b0;
          last_dm <= win_dm;
        end
        default: begin
          state   <= IDLE;
          if_gnt  <= 1'b0;
          dm_gnt  <= 1'b0;
          if_done <= 1'b0;
          dm_done <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: three instances (MEM_LAT 2, 1, 15) share stimulus and are
// checked against a transaction-timing model (grant at s, gnt s+1..s+L, done s+L+1).
module tb_mem_arb;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_f = 1'b1;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;

  logic [2:0]    if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr [3];
  logic [DW-1:0] mem_wdata [3];
  logic [DW-1:0] if_rdata [3];
  logic [DW-1:0] dm_rdata [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .clk(clk), .rst_f(rst_f),
      .if_req(if_req), .if_addr(if_addr),
      .if_gnt(if_gnt[g]), .if_done(if_done[g]), .if_rdata(if_rdata[g]),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt[g]), .dm_done(dm_done[g]), .dm_rdata(dm_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata), .busy(busy[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int c = 0;

  // Reference model state per instance: one outstanding transaction at most.
  int            lat [3] = '{2, 1, 15};
  bit            act [3] = '{0, 0, 0};
  int            s   [3];
  bit            wdm [3];
  bit            lastdm [3] = '{1, 1, 1};
  bit            twe [3];
  logic [AW-1:0] tadr [3];
  logic [DW-1:0] twd [3];
  logic [DW-1:0] rif [3] = '{0, 0, 0};
  logic [DW-1:0] rdm [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit g, d;
    for (int k = 0; k < 3; k++) begin
      g = act[k] && c >= s[k] + 1 && c <= s[k] + lat[k];
      d = act[k] && c == s[k] + lat[k] + 1;
      chk($sformatf("ctl%0d@%0d", k, c),
          {if_gnt[k], dm_gnt[k], if_done[k], dm_done[k], mem_en[k], busy[k]},
          {g && !wdm[k], g && wdm[k], d && !wdm[k], d && wdm[k], g, g || d});
      if (g) begin
        chk($sformatf("addr%0d@%0d", k, c), mem_addr[k], tadr[k]);
        chk($sformatf("we%0d@%0d", k, c), mem_we[k], twe[k]);
        if (wdm[k]) chk($sformatf("wdata%0d@%0d", k, c), mem_wdata[k], twd[k]);
      end
      chk($sformatf("rdata%0d@%0d", k, c), {if_rdata[k], dm_rdata[k]}, {rif[k], rdm[k]});
    end
  endtask

  task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] rd);
    @(negedge clk);
    c++;
    check_all();
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
    mem_rdata = rd;
    for (int k = 0; k < 3; k++) begin
      // Read data is taken in the last ACCESS cycle.
      if (act[k] && c == s[k] + lat[k] && !twe[k]) begin
        if (wdm[k]) rdm[k] = rd;
        else        rif[k] = rd;
      end
      if ((!act[k] || c >= s[k] + lat[k] + 2) && (ir || dr)) begin
        if (ir && dr) wdm[k] = !lastdm[k];
        else          wdm[k] = dr;
        lastdm[k] = wdm[k];
        act[k]    = 1'b1;
        s[k]      = c;
        tadr[k]   = wdm[k] ? da : ia;
        twe[k]    = wdm[k] && dw;
        twd[k]    = dwd;
      end
    end
  endtask

  task automatic idle(input int n, input logic [DW-1:0] rd);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, rd);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    c++;
    if_req = 1'b0; dm_req = 1'b0;
    rst_f = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      act[k] = 1'b0; lastdm[k] = 1'b1; rif[k] = '0; rdm[k] = '0;
    end
    check_all();
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_mem%0d", k), {mem_we[k], mem_addr[k], mem_wdata[k]}, '0);
    repeat (n) begin
      @(negedge clk);
      c++;
      check_all();
    end
    rst_f = 1'b1;
  endtask

  initial begin
    do_reset(2);

    // Single fetch read, MEM_LAT=2 timing and captured data.
    cycle(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 32'hDEADBEEF);
    idle(4, 32'hDEADBEEF);
    chk("fetch_rdata", if_rdata[0], 32'hDEADBEEF);
    idle(14, 32'h0);

    // Both requests held: fetch first, then data write, then alternation.
    repeat (14) cycle(1'b1, 16'h0040, 1'b1, 1'b1, 16'h0020, 32'h12345678, $urandom);
    idle(18, 32'h0);

    // Data request arriving mid-fetch waits for the next IDLE.
    cycle(1'b1, 16'h0044, 1'b0, 1'b0, '0, '0, 32'h1111);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h2222);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, 16'h0024, '0, 32'h3333);
    idle(18, 32'h0);

    // Write after read leaves dm_rdata untouched.
    cycle(1'b0, '0, 1'b1, 1'b0, 16'h0030, '0, 32'hA5A5A5A5);
    idle(18, 32'hA5A5A5A5);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0030, 32'h00000001, 32'h5A5A5A5A);
    idle(18, 32'h5A5A5A5A);
    for (int k = 0; k < 3; k++) chk($sformatf("wr_hold%0d", k), dm_rdata[k], 32'hA5A5A5A5);

    // Reset in the middle of an access, then a clean fetch.
    cycle(1'b1, 16'h0050, 1'b0, 1'b0, '0, '0, 32'h4444);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h4444);
    do_reset(1);
    cycle(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0070, '0, 32'h5555);
    idle(18, 32'h6666);

    // Randomized traffic.
    repeat (1500)
      cycle(($urandom % 3) != 0, 16'($urandom), ($urandom % 3) != 0, 1'($urandom),
            16'($urandom), $urandom, $urandom);
    do_reset(1);
    repeat (200)
      cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), $urandom, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
